// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared types and helpers for FIFO-side stream stages.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

  typedef enum logic {
    FILL     = 1'b0,
    WAIT_OUT = 1'b1
  } pack_state_e;

  function automatic int lane_cnt_w(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_packer_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pop_packer_if
// Brief   : FIFO read port plus packed valid/ready output stream.
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_pop_packer_if #(
  parameter int DWIDTH = 4,
  parameter int PACK   = 4
);
  localparam int OWIDTH   = DWIDTH * PACK;
  localparam int C_LANE_W = fifo_pkg::lane_cnt_w(PACK);

  logic                fifo_empty;
  logic [DWIDTH-1:0]   fifo_dout;
  logic                fifo_ren;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [OWIDTH-1:0]   out_data;
  logic [C_LANE_W-1:0] out_lanes;

  modport master (
    input  fifo_empty, fifo_dout, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_lanes
  );

  modport slave (
    output fifo_empty, fifo_dout, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_lanes
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pop_packer_vr_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : vr_out_reg
// Brief   : Valid/ready output register with load, hold and clear.
// Revision: 1.0 - initial release
// ============================================================================
module vr_out_reg #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic [W-1:0] load_data,
  input  wire logic         ready,
  output logic              valid,
  output logic [W-1:0]      data,
  output logic              free
);

  assign free = ~valid | ready;

  // Callers only assert load while free, so a held word is never overwritten.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_pop_packer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pop_packer
// Brief   : Pops FIFO entries and packs PACK lanes per output word, with flush.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_pop_packer
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 4,
  parameter int PACK   = 4
) (
  input wire logic          clk,
  input wire logic          rst_n,
  fifo_pop_packer_if.master bus
);

  localparam int OWIDTH   = DWIDTH * PACK;
  localparam int C_LANE_W = lane_cnt_w(PACK);
  localparam logic [C_LANE_W-1:0] C_PACK_CNT  = C_LANE_W'(PACK);
  localparam logic [C_LANE_W-1:0] C_LAST_LANE = C_LANE_W'(PACK - 1);

  pack_state_e                  r_state;
  pack_state_e                  w_state_next;
  logic [C_LANE_W-1:0]          r_cnt;
  logic [OWIDTH-1:0]            r_acc;
  logic                         r_flush_pend;
  logic [OWIDTH-1:0]            w_acc_pop;
  logic                         w_fifo_ren;
  logic                         w_complete;
  logic                         w_flush_now;
  logic                         w_load;
  logic                         w_out_free;
  logic                         w_out_valid;
  logic [C_LANE_W+OWIDTH-1:0]   w_load_word;
  logic [C_LANE_W+OWIDTH-1:0]   w_out_word;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL:     if ((w_complete | w_flush_now) & ~w_out_free) w_state_next = WAIT_OUT;
      WAIT_OUT: if (w_out_free) w_state_next = FILL;
      default:  w_state_next = FILL;
    endcase
  end

  always_comb begin
    w_fifo_ren  = rst_n & ~bus.fifo_empty & (r_state == FILL) & (r_cnt < C_PACK_CNT)
                & ~bus.flush & ~r_flush_pend;
    w_acc_pop   = r_acc;
    if (r_cnt < C_PACK_CNT) w_acc_pop[int'(r_cnt)*DWIDTH +: DWIDTH] = bus.fifo_dout;
    w_complete  = w_fifo_ren & (r_cnt == C_LAST_LANE);
    w_flush_now = bus.flush & (r_state == FILL) & (r_cnt != '0);
    // A waiting word (full or flushed partial) always leaves on the first free edge.
    w_load      = w_out_free & ((r_state == WAIT_OUT) | w_complete | w_flush_now);
    w_load_word = w_complete ? {C_PACK_CNT, w_acc_pop} : {r_cnt, r_acc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_fifo_ren) begin
        r_cnt <= r_cnt + C_LANE_W'(1);
        r_acc <= w_acc_pop;
      end
      if (w_load)           r_flush_pend <= 1'b0;
      else if (w_flush_now) r_flush_pend <= 1'b1;
    end
  end

  vr_out_reg #(.W(C_LANE_W + OWIDTH)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .load_data (w_load_word),
    .ready     (bus.out_ready),
    .valid     (w_out_valid),
    .data      (w_out_word),
    .free      (w_out_free)
  );

  assign bus.fifo_ren                  = w_fifo_ren;
  assign bus.out_valid                 = w_out_valid;
  assign {bus.out_lanes, bus.out_data} = w_out_word;

endmodule
`default_nettype wire
